// File: rtl/wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_arbiter: two-source register-file writeback arbiter with anti-starvation |
// | for the multdiv port; optional busy scoreboard (macro WB_SCOREBOARD_EN).     |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  input  logic        b_issue,
  input  logic [4:0]  b_issue_reg,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] busy_mask
);

  localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        w_b_prio;
  logic        w_a_xfer;
  logic        w_b_xfer;

  // B overrides A only once it has waited the full starvation window
  assign w_b_prio = (starve_cnt_q == c_starve_limit);
  assign a_ready  = !ctrl_reset && a_valid && !(b_valid && w_b_prio);
  assign b_ready  = !ctrl_reset && b_valid && (!a_valid || w_b_prio);
  assign w_a_xfer = a_valid && a_ready;
  assign w_b_xfer = b_valid && b_ready;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!b_valid || w_b_xfer) begin
      starve_cnt_d = 3'd0;
    end else if (starve_cnt_q != c_starve_limit) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (w_a_xfer) begin
      we_d    = (a_reg != 5'd0);
      wreg_d  = a_reg;
      wdata_d = a_data;
    end else if (w_b_xfer) begin
      we_d    = (b_reg != 5'd0);
      wreg_d  = b_reg;
      wdata_d = b_data;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      starve_cnt_q <= 3'd0;
      we_q         <= 1'b0;
      wreg_q       <= 5'd0;
      wdata_q      <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Set is applied after clear so a same-edge reissue keeps the bit busy
  always_comb begin
    busy_d = busy_q;
    if (w_b_xfer) begin
      busy_d[b_reg] = 1'b0;
    end
    if (b_issue && (b_issue_reg != 5'd0)) begin
      busy_d[b_issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;
`else
  logic w_unused_issue;

  assign w_unused_issue = ^{b_issue, b_issue_reg};
  assign busy_mask      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_wb_arbiter: self-checking bench for wb_arbiter with a transaction-level   |
// | reference model. Revision: 1.0                                               |
// +-----------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int STARVE_LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        a_valid, b_valid, b_issue;
  logic [4:0]  a_reg, b_reg, b_issue_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] busy_mask;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          waitcnt;
  logic        ea, eb;
  logic        e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data, e_busy;

  wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .b_issue(b_issue), .b_issue_reg(b_issue_reg),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .busy_mask(busy_mask)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    waitcnt = 0; ea = 1'b0; eb = 1'b0;
    e_we = 1'b0; e_reg = '0; e_data = '0; e_busy = '0;
  endtask

  // Drive one cycle of inputs at the falling edge and predict the grants
  task automatic apply(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic bi, input logic [4:0] bir);
    @(negedge clock);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    b_issue = bi; b_issue_reg = bir;
    #1;
    ea = av && !(bv && waitcnt >= STARVE_LIMIT);
    eb = bv && (!av || waitcnt >= STARVE_LIMIT);
  endtask

  // Advance the model across the rising edge
  task automatic commit();
    logic ax, bx;
    ax = a_valid && ea;
    bx = b_valid && eb;
    if (ax) begin
      e_we = (a_reg != 5'd0); e_reg = a_reg; e_data = a_data;
    end else if (bx) begin
      e_we = (b_reg != 5'd0); e_reg = b_reg; e_data = b_data;
    end else begin
      e_we = 1'b0;
    end
    if (b_valid && !eb) waitcnt++;
    else                waitcnt = 0;
    if (SB) begin
      if (bx) e_busy[b_reg] = 1'b0;
      if (b_issue && b_issue_reg != 5'd0) e_busy[b_issue_reg] = 1'b1;
    end
    @(posedge clock);
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h2222_2222;
    b_issue = 1'b1; b_issue_reg = 5'd4;
    model_reset();
    #13;
    n_vec++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
    end
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%h busy=%h want all 0",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask);
    end
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0; b_issue = 1'b0;
    ctrl_reset = 1'b0;
  endtask

  task automatic test_a_write();
    apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    n_vec++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_err++; $display("FAIL a_write_ready: got %b want 10", {a_ready, b_ready});
    end
    commit();
    idle();
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL a_write_port: got we=%b reg=%0d data=%h want we=1 reg=5 data=deadbeef",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    commit();
    idle();
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL a_write_idle: got we=%b reg=%0d data=%h want we=0 reg=5 data=deadbeef",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    commit();
  endtask

  task automatic test_reg_zero();
    apply(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    n_vec++;
    if (a_ready !== 1'b1) begin
      n_err++; $display("FAIL reg0_ready: got %b want 1", a_ready);
    end
    commit();
    idle();
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b0, 5'd0, 32'h0000_1234}) begin
      n_err++;
      $display("FAIL reg0_port: got we=%b reg=%0d data=%h want we=0 reg=0 data=00001234",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    commit();
  endtask

  task automatic test_starvation();
    logic [4:0]  ar, br;
    logic [31:0] ad, bd;
    ar = 5'd1; br = 5'd2; ad = 32'd0; bd = 32'd0;
    for (int i = 0; i < 2 * STARVE_LIMIT + 2; i++) begin
      ar = 5'($urandom_range(1, 31)); ad = $urandom;
      if (i == 0 || i == STARVE_LIMIT + 1) begin
        br = 5'($urandom_range(1, 31)); bd = $urandom;
      end
      apply(1'b1, ar, ad, 1'b1, br, bd, 1'b0, 5'd0);
      n_vec++;
      if ({a_ready, b_ready} !== ((i == STARVE_LIMIT || i == 2 * STARVE_LIMIT + 1) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL starve_grant[%0d]: got %b", i, {a_ready, b_ready});
      end
      n_vec++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {e_we, e_reg, e_data}) begin
        n_err++;
        $display("FAIL starve_port[%0d]: got %b/%0d/%h want %b/%0d/%h", i,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e_we, e_reg, e_data);
      end
      commit();
    end
    idle();
    commit();
  endtask

  task automatic test_scoreboard();
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    commit();
    idle();
    n_vec++;
    if (busy_mask !== (SB ? 32'h0000_0200 : 32'h0)) begin
      n_err++; $display("FAIL sb_issue9: got %h want %h", busy_mask, SB ? 32'h200 : 32'h0);
    end
    commit();
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 5'd9);
    n_vec++;
    if ({a_ready, b_ready} !== 2'b01) begin
      n_err++; $display("FAIL sb_b_ready: got %b want 01", {a_ready, b_ready});
    end
    commit();
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE_0019, 1'b1, 5'd3);
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask} !==
        {1'b1, 5'd9, 32'hCAFE_0009, (SB ? 32'h0000_0200 : 32'h0)}) begin
      n_err++;
      $display("FAIL sb_same_edge: got we=%b reg=%0d data=%h busy=%h",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask);
    end
    commit();
    idle();
    n_vec++;
    if ({ctrl_writeEnable, busy_mask} !== {1'b1, (SB ? 32'h0000_0008 : 32'h0)}) begin
      n_err++; $display("FAIL sb_clear9: got we=%b busy=%h", ctrl_writeEnable, busy_mask);
    end
    commit();
    apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd0);
    commit();
    idle();
    n_vec++;
    if (busy_mask !== 32'h0) begin
      n_err++; $display("FAIL sb_empty: got %h want 00000000", busy_mask);
    end
    commit();
  endtask

  task automatic test_reset_midop();
    apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    commit();
    apply(1'b1, 5'd6, 32'h6666, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0);
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask} !== {e_we, e_reg, e_data, e_busy}) begin
      n_err++; $display("FAIL midop_pre: busy got %h want %h", busy_mask, e_busy);
    end
    #2 ctrl_reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask} !== 72'd0) begin
      n_err++;
      $display("FAIL midop_reset: got rdy=%b we=%b reg=%0d data=%h busy=%h want all 0",
               {a_ready, b_ready}, ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask);
    end
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
    ctrl_reset = 1'b0;
    apply(1'b1, 5'd6, 32'h6666, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0);
    n_vec++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_err++; $display("FAIL midop_first: got %b want 10", {a_ready, b_ready});
    end
    commit();
    idle();
    n_vec++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd6, 32'h6666}) begin
      n_err++;
      $display("FAIL midop_write: got %b/%0d/%h want 1/6/6666",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    commit();
  endtask

  task automatic test_random();
    logic        pa, pb;
    logic [4:0]  ar, br;
    logic [31:0] ad, bd;
    pa = 1'b0; pb = 1'b0; ar = '0; br = '0; ad = '0; bd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; ar = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; br = 5'($urandom_range(0, 31)); bd = $urandom;
      end
      apply(pa, ar, ad, pb, br, bd, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      n_vec++;
      if ({a_ready, b_ready} !== {ea, eb}) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, {a_ready, b_ready}, {ea, eb});
      end
      n_vec++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask} !== {e_we, e_reg, e_data, e_busy}) begin
        n_err++;
        $display("FAIL rand_port[%0d]: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask,
                 e_we, e_reg, e_data, e_busy);
      end
      if (ea) pa = 1'b0;
      if (eb) pb = 1'b0;
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_reg_zero();
    test_starvation();
    test_scoreboard();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive cycles B may wait before it gets priority (range 1..7).
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 ctrl_reset  input  1  asynchronous, active-high reset.
REQ-004 a_valid / a_ready  input / output  1 / 1  ALU writeback request and grant.
REQ-005 a_reg / a_data  input  5 / 32  ALU destination register and result.
REQ-006 b_valid / b_ready  input / output  1 / 1  multdiv writeback request and grant.
REQ-007 b_reg / b_data  input  5 / 32  multdiv destination register and result.
REQ-008 b_issue / b_issue_reg  input  1 / 5  multdiv operation launched; destination marked busy.
REQ-009 ctrl_writeEnable / ctrl_writeReg / data_writeReg  output  1 / 5 / 32  registered drive of the register-file write port.
REQ-010 busy_mask  output  32  bit n set = register n awaits a multdiv result.

Function
REQ-011 A transfer occurs on a requester when valid and ready are both high at a rising edge; at most one transfer per cycle in total.
REQ-012 Requesters hold valid, reg and data stable until transfer; ready is combinational from the valid inputs and arbiter state only.
REQ-013 Arbitration: only one valid -> that one is granted; both valid -> A is granted unless starve_cnt == STARVE_LIMIT, in which case B is granted.
REQ-014 starve_cnt (3 bits): +1 per cycle with b_valid high and b_ready low, saturating at STARVE_LIMIT; cleared on a B transfer or when b_valid is low.
REQ-015 One-cycle latency: a transfer at edge N drives ctrl_writeReg/data_writeReg with the granted reg/data after edge N, and ctrl_writeEnable high for exactly that cycle.
REQ-016 A transfer with destination register 0 completes the handshake but drives ctrl_writeEnable low; ctrl_writeReg/data_writeReg still update.
REQ-017 Cycle with no transfer: ctrl_writeEnable low; ctrl_writeReg/data_writeReg hold their previous values.
REQ-018 b_issue high at an edge sets busy_mask[b_issue_reg] after that edge; b_issue_reg == 0 sets nothing.
REQ-019 A B transfer clears busy_mask[b_reg] after the edge.
REQ-020 Same-edge set and clear of the same bit: set wins; different bits: both take effect.
REQ-021 A transfers never modify busy_mask.

Reset
REQ-022 While ctrl_reset is high, asynchronously and independent of clock: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, busy_mask=0, starve_cnt=0.
REQ-023 a_ready and b_ready are low while ctrl_reset is high.
REQ-024 Reset mid-operation drops in-flight requests without a write; requesters re-present after release.
REQ-025 The first transfer can occur at the first rising edge after ctrl_reset deasserts.

Configuration
REQ-026 Macro WB_SCOREBOARD_EN defined: busy_mask logic per REQ-018..REQ-021.
REQ-027 Macro WB_SCOREBOARD_EN undefined: no scoreboard storage; busy_mask tied to 0; b_issue/b_issue_reg ignored; arbitration unchanged.

Verification
REQ-028 a_valid=1, a_reg=5, a_data=0xDEADBEEF, b_valid=0 -> a_ready=1; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; following idle cycle ctrl_writeEnable=0.
REQ-029 a_valid and b_valid held high (STARVE_LIMIT=4) -> A granted for 4 cycles, B granted in cycle 5, then A again; starve_cnt back to 0.
REQ-030 a_valid=1, a_reg=0, a_data=0x1234 -> a_ready=1; next cycle ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0x1234.
REQ-031 WB_SCOREBOARD_EN: b_issue with reg 9 -> busy_mask=0x00000200; B transfer to reg 9 while b_issue to reg 9 at the same edge -> bit 9 stays set; later B transfer to reg 9 -> busy_mask=0.
REQ-032 ctrl_reset pulsed mid-cycle with both requests pending and busy_mask=0x00000010 -> outputs and busy_mask 0 immediately, readies low; after release, A granted first.
REQ-033 WB_SCOREBOARD_EN undefined: b_issue with reg 3 -> busy_mask stays 0; write traffic identical to REQ-028.
